// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command stage for the 5-bit 4-op ALU. Takes one operand/opcode
//               command per handshake, registers it onto the ALU inputs,
//               captures the ALU result and presents it downstream with flags.
//               Optional feature macro: ALU_SEQ_ACC_EN (operand A may come from
//               the last accepted result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_borrow,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_SUB  = 2'b01;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic             capture;
    logic             retire;
    logic [WIDTH-1:0] a_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid && in_ready) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == ST_IDLE) && in_valid && in_ready;
        capture   = (state == ST_EXEC);
        retire    = (state == ST_DONE) && out_ready;
        out_valid = (state == ST_DONE);
    end

    // Registered so that in_ready stays low through reset and rises on the
    // first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (state_nxt == ST_IDLE);
        end
    end

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] last_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_result <= '0;
        end else if (retire) begin
            last_result <= out_result;
        end
    end

    assign a_sel = in_acc ? last_result : in_a;
`else
    logic unused_acc;
    assign unused_acc = in_acc;
    assign a_sel      = in_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 2'b00;
            out_borrow <= 1'b0;
        end else if (accept) begin
            alu_a      <= a_sel;
            alu_b      <= in_b;
            alu_op     <= in_op;
            out_borrow <= (in_op == OP_SUB) && (a_sel < in_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_zero   <= 1'b0;
        end else if (capture) begin
            out_result <= alu_result;
            out_zero   <= (alu_result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (retire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer with a small ALU
//               model attached to the alu_* port group.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_a;
    logic [4:0] in_b;
    logic [1:0] in_op;
    logic       in_acc;
    logic [4:0] alu_a;
    logic [4:0] alu_b;
    logic [1:0] alu_op;
    logic [4:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_result;
    logic       out_zero;
    logic       out_borrow;
    logic [7:0] op_count;

    alu_cmd_sequencer #(.WIDTH(5), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_borrow (out_borrow),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The ALU the sequencer drives
    always_comb begin
        alu_result = 5'd0;
        case (alu_op)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = alu_a & alu_b;
            2'b11: alu_result = alu_a | alu_b;
            default: alu_result = 5'd0;
        endcase
    end

    typedef struct {
        int a;
        int b;
        int op;
        int acc;
        int res;
        int zero;
        int borrow;
    } vec_t;

    vec_t tbl[8];
    vec_t b2b[4];

    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;
    int last_res = 0;

`ifdef ALU_SEQ_ACC_EN
    localparam int ACC_ON = 1;
`else
    localparam int ACC_ON = 0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_a(input int a, input int acc);
        return (ACC_ON != 0 && acc != 0) ? last_res : a;
    endfunction

    function automatic int model_res(input int a, input int b, input int op);
        case (op)
            0: return (a + b) % 32;
            1: return (a - b + 32) % 32;
            2: return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic send_cmd(input int a, input int b, input int op, input int acc);
        int t = 0;
        while (!in_ready && t < 10) begin
            step();
            t++;
        end
        chk("send_ready", in_ready, 1);
        in_a     = 5'(a);
        in_b     = 5'(b);
        in_op    = 2'(op);
        in_acc   = acc[0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Called one edge after acceptance: EXEC now, result visible after next edge.
    task automatic collect(input int er, input int ez, input int eb, input int delay);
        chk("exec_no_valid", out_valid, 0);
        step();
        chk("latency_valid", out_valid, 1);
        chk("result", out_result, 32'(er));
        chk("zero", out_zero, 32'(ez));
        chk("borrow", out_borrow, 32'(eb));
        chk("busy_ready", in_ready, 0);
        for (int i = 0; i < delay; i++) step();
        chk("hold_result", out_result, 32'(er));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
        last_res  = er;
        chk("valid_cleared", out_valid, 0);
        chk("op_count", op_count, 32'(exp_count));
    endtask

    task automatic run_model_cmd(input int a, input int b, input int op, input int acc, input int delay);
        int ae;
        int r;
        ae = eff_a(a, acc);
        r  = model_res(ae, b, op);
        send_cmd(a, b, op, acc);
        collect(r, (r == 0) ? 1 : 0, (op == 1 && ae < b) ? 1 : 0, delay);
    endtask

    initial begin
        tbl[0] = '{a:12, b:7,  op:0, acc:0, res:19, zero:0, borrow:0};
        tbl[1] = '{a:31, b:1,  op:0, acc:0, res:0,  zero:1, borrow:0};
        tbl[2] = '{a:3,  b:5,  op:1, acc:0, res:30, zero:0, borrow:1};
        tbl[3] = '{a:22, b:13, op:2, acc:0, res:4,  zero:0, borrow:0};
        tbl[4] = '{a:22, b:13, op:3, acc:0, res:31, zero:0, borrow:0};
        tbl[5] = '{a:5,  b:5,  op:1, acc:0, res:0,  zero:1, borrow:0};
        tbl[6] = '{a:4,  b:3,  op:0, acc:0, res:7,  zero:0, borrow:0};
`ifdef ALU_SEQ_ACC_EN
        tbl[7] = '{a:9,  b:10, op:0, acc:1, res:17, zero:0, borrow:0};
`else
        tbl[7] = '{a:9,  b:10, op:0, acc:1, res:19, zero:0, borrow:0};
`endif
        b2b[0] = '{a:1,  b:2,  op:0, acc:0, res:3,  zero:0, borrow:0};
        b2b[1] = '{a:10, b:4,  op:1, acc:0, res:6,  zero:0, borrow:0};
        b2b[2] = '{a:15, b:9,  op:2, acc:0, res:9,  zero:0, borrow:0};
        b2b[3] = '{a:16, b:1,  op:3, acc:0, res:17, zero:0, borrow:0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_acc = 1'b0; out_ready = 1'b0;

        // Reset values
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_result", out_result, 0);
        #9 rst_n = 1'b1;
        #1 chk("rel_in_ready_low", in_ready, 0);
        step();
        chk("rel_in_ready_high", in_ready, 1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            send_cmd(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].acc);
            collect(tbl[i].res, tbl[i].zero, tbl[i].borrow, i % 3);
        end

        // Downstream stall with a second command waiting
        send_cmd(22, 13, 2, 0);
        step();
        chk("stall_valid0", out_valid, 1);
        in_a = 5'd22; in_b = 5'd13; in_op = 2'd3; in_acc = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_result", out_result, 4);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_alu_op", alu_op, 2);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
        last_res = 4;
        chk("stall_count", op_count, 32'(exp_count));
        chk("stall_idle_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("stall_second_op", alu_op, 3);
        collect(31, 0, 0, 0);

        // Back-to-back: in_valid and out_ready held high
        begin
            int k = 0, got = 0, cyc = 0, last = -1;
            logic acc_now;
            out_ready = 1'b1;
            in_a = 5'(b2b[0].a); in_b = 5'(b2b[0].b); in_op = 2'(b2b[0].op); in_acc = 1'b0;
            in_valid = 1'b1;
            while (got < 4 && cyc < 40) begin
                acc_now = in_ready && in_valid;
                if (out_valid) begin
                    chk("b2b_result", out_result, 32'(b2b[got].res));
                    if (got > 0) chk("b2b_spacing", 32'(cyc - last), 3);
                    last = cyc;
                    got++;
                end
                step();
                cyc++;
                if (acc_now) begin
                    k++;
                    if (k < 4) begin
                        in_a = 5'(b2b[k].a); in_b = 5'(b2b[k].b); in_op = 2'(b2b[k].op);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk("b2b_all_results", 32'(got), 4);
            exp_count += 4;
            last_res = 17;
            chk("b2b_count", op_count, 32'(exp_count));
        end

        // out_ready high while nothing is valid
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        chk("idle_ready_count", op_count, 32'(exp_count));
        chk("idle_alu_a_kept", alu_a, 16);

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            run_model_cmd($urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
        end

        // Reset mid-DONE discards the pending result
        send_cmd(12, 7, 0, 0);
        step();
        chk("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", op_count, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel2_in_ready_low", in_ready, 0);
        step();
        chk("rel2_in_ready_high", in_ready, 1);
        exp_count = 0;
        last_res  = 0;

        // Run the counter through its wrap
        for (int i = 0; i < 257; i++) begin
            run_model_cmd($urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 3), $urandom_range(0, 1), 0);
        end
        chk("wrap_count", op_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
